ser2par_onehot: RTL and testbench

- Parametrised successor to the two-wire serial-to-one-hot output expander.
- Receives DATA_W-bit frames on an scl/sda pair, framed by START (sda falls while scl is high) and STOP (sda rises while scl is high).
- Decodes each completed frame to a 2**DATA_W one-hot output bus.
- Runs entirely in the system clock domain; scl/sda are oversampled. Adds framing-error detection, a valid strobe and a busy flag.

---
 rtl/s2p_pkg.sv | 40 ++++
 rtl/s2p_bus_cond.sv | 46 ++++
 rtl/ser2par_onehot.sv | 172 +++++++++++++++++
 tb/tb_ser2par_onehot.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// Shared types and helpers for the two-wire serial-to-one-hot receiver family.
// Define S2P_PARITY_EN to add one even-parity bit after the data bits of every frame.
package s2p_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE      = 2'd0;
  localparam state_t S_RECV      = 2'd1;
  localparam state_t S_WAIT_STOP = 2'd2;

  localparam int unsigned MAX_OUT_W = 256;

`ifdef S2P_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Number of scl-clocked bits that make up one complete frame.
  function automatic int unsigned frame_bits(input int unsigned data_w);
    return data_w + PARITY_BITS;
  endfunction

  // Bit counter must hold frame_bits(), which is at most data_w+1.
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 2);
  endfunction

  // Rotated decode kept from the predecessor: v selects bit (v + out_w - 1) mod out_w.
  function automatic logic [MAX_OUT_W-1:0] onehot_map(input logic [7:0] v,
                                                      input int unsigned out_w);
    logic [MAX_OUT_W-1:0] oh;
    int unsigned          idx;
    oh       = '0;
    idx      = (32'(v) + out_w - 1) % out_w;
    oh[idx[7:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/s2p_bus_cond.sv
// Two-wire bus conditioner: synchronises scl/sda into clk and flags START, STOP
// and scl rising edges from a prev/cur sample pair.
module s2p_bus_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_start_c,
  output logic o_stop_c,
  output logic o_scl_rise_c,
  output logic o_sda_cur_c
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl_cur;
  logic                   w_sda_cur;

  assign w_scl_cur = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_cur = r_sda_sync[SYNC_STAGES-1];

  // Reset to the idle bus level so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl_cur;
      r_sda_prev <= w_sda_cur;
    end
  end

  assign o_start_c    = w_scl_cur & r_scl_prev &  r_sda_prev & ~w_sda_cur;
  assign o_stop_c     = w_scl_cur & r_scl_prev & ~r_sda_prev &  w_sda_cur;
  assign o_scl_rise_c = ~r_scl_prev & w_scl_cur;
  assign o_sda_cur_c  = w_sda_cur;

endmodule

// File: rtl/ser2par_onehot.sv
// Serial-to-one-hot expander: receives DATA_W-bit two-wire frames and decodes each good
// frame onto a 2**DATA_W one-hot bus. S2P_PARITY_EN adds an even-parity bit per frame.
module ser2par_onehot
  import s2p_pkg::*;
#(
  parameter  int unsigned DATA_W      = 4,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned OUT_W       = 1 << DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl,
  input  logic             sda,
  output logic [OUT_W-1:0] outhigh,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned FRAME_BITS = frame_bits(DATA_W);
  localparam int unsigned CNT_W      = cnt_width(DATA_W);

  logic                  w_start;
  logic                  w_stop;
  logic                  w_rise;
  logic                  w_sda;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic                  r_stop_arm;
  logic                  w_stop_arm_nxt;
  logic [OUT_W-1:0]      w_outhigh_nxt;
  logic                  w_valid_nxt;
  logic                  w_err_nxt;
  logic                  w_busy_nxt;
  logic [DATA_W-1:0]     w_data;
  logic                  w_frame_ok;
  logic [OUT_W-1:0]      w_decoded;
  logic                  w_extra_bit;

  s2p_bus_cond #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_cond (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_scl        (scl),
    .i_sda        (sda),
    .o_start_c    (w_start),
    .o_stop_c     (w_stop),
    .o_scl_rise_c (w_rise),
    .o_sda_cur_c  (w_sda)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_data    = r_shift[FRAME_BITS-1 -: DATA_W];
  assign w_decoded = OUT_W'(onehot_map(8'(w_data), OUT_W));

`ifdef S2P_PARITY_EN
  assign w_frame_ok = ~(^r_shift);
`else
  assign w_frame_ok = 1'b1;
`endif

  // A frame ending in a 1 needs one clock with sda low to set up STOP; only that
  // single low clock is tolerated, anything else after the last bit is an extra bit.
  assign w_extra_bit = w_rise & (w_sda | r_stop_arm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_RECV;
      end
      S_RECV: begin
        if (w_start)                                  w_state_nxt = S_RECV;
        else if (w_stop)                              w_state_nxt = S_IDLE;
        else if (w_rise && w_cnt_inc == CNT_W'(FRAME_BITS)) w_state_nxt = S_WAIT_STOP;
      end
      S_WAIT_STOP: begin
        if (w_start)          w_state_nxt = S_RECV;
        else if (w_stop)      w_state_nxt = S_IDLE;
        else if (w_extra_bit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_stop_arm_nxt = r_stop_arm;
    w_outhigh_nxt  = outhigh;
    w_valid_nxt    = 1'b0;
    w_err_nxt      = 1'b0;
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_cnt_nxt      = '0;
          w_shift_nxt    = '0;
          w_stop_arm_nxt = 1'b0;
        end
      end
      S_RECV: begin
        if (w_start) begin
          w_cnt_nxt      = '0;
          w_shift_nxt    = '0;
          w_stop_arm_nxt = 1'b0;
        end else if (w_stop) begin
          w_err_nxt = 1'b1;
        end else if (w_rise) begin
          w_shift_nxt = (r_shift << 1) | FRAME_BITS'(w_sda);
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      S_WAIT_STOP: begin
        if (w_start) begin
          w_cnt_nxt      = '0;
          w_shift_nxt    = '0;
          w_stop_arm_nxt = 1'b0;
        end else if (w_stop) begin
          if (w_frame_ok) begin
            w_outhigh_nxt = w_decoded;
            w_valid_nxt   = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_extra_bit) begin
          w_err_nxt = 1'b1;
        end else if (w_rise) begin
          w_stop_arm_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_stop_arm <= 1'b0;
      outhigh    <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_stop_arm <= w_stop_arm_nxt;
      outhigh    <= w_outhigh_nxt;
      data_valid <= w_valid_nxt;
      frame_err  <= w_err_nxt;
      busy       <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_ser2par_onehot.sv
// Scoreboard bench for ser2par_onehot: a frame-level model queues expected output events,
// a monitor pops and checks them whenever data_valid or frame_err is seen.
module tb_ser2par_onehot;

  localparam int unsigned DATA_W      = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned OUT_W       = 16;
  localparam int unsigned HALF        = 4;
`ifdef S2P_PARITY_EN
  localparam int unsigned FRAME_BITS  = DATA_W + 1;
`else
  localparam int unsigned FRAME_BITS  = DATA_W;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             scl;
  logic             sda;
  logic [OUT_W-1:0] outhigh;
  logic             data_valid;
  logic             frame_err;
  logic             busy;

  typedef struct {
    bit               is_err;
    logic [OUT_W-1:0] oh;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  bit               bits_q[$];
  bit               tx_q[$];
  bit               in_frame = 1'b0;
  logic [OUT_W-1:0] model_oh = '0;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc   = 0;

  ser2par_onehot #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl        (scl),
    .sda        (sda),
    .outhigh    (outhigh),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkv(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checki(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  function automatic void push_exp(input bit is_err, input int cause_cyc);
    exp_t e;
    e.is_err = is_err;
    e.oh     = model_oh;
    e.cyc    = cause_cyc + SYNC_STAGES + 1;
    exp_q.push_back(e);
  endfunction

  function automatic void model_start();
    bits_q.delete();
    in_frame = 1'b1;
  endfunction

  // One clocked bit. After a full frame a single low clock is the STOP setup;
  // any other clock there is an extra bit and ends the frame with an error.
  function automatic void model_bit(input bit b, input int c);
    if (in_frame) begin
      if (bits_q.size() < FRAME_BITS) bits_q.push_back(b);
      else if (bits_q.size() == FRAME_BITS && b == 1'b0) bits_q.push_back(b);
      else begin
        push_exp(1'b1, c);
        in_frame = 1'b0;
      end
    end
  endfunction

  function automatic void model_stop(input int c);
    int unsigned v;
    int unsigned ones;
    if (!in_frame) return;
    in_frame = 1'b0;
    if (bits_q.size() < FRAME_BITS) begin
      push_exp(1'b1, c);
      return;
    end
    v    = 0;
    ones = 0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (i < DATA_W) v = v * 2 + 32'(bits_q[i]);
      ones += 32'(bits_q[i]);
    end
    if (FRAME_BITS > DATA_W && (ones % 2) == 1) begin
      push_exp(1'b1, c);
    end else begin
      model_oh = OUT_W'(1) << ((v + OUT_W - 1) % OUT_W);
      push_exp(1'b0, c);
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (data_valid === 1'b1 || frame_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: valid=%b err=%b outhigh=%h cycle %0d",
                 data_valid, frame_err, outhigh, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check1("event_err", frame_err, mon_e.is_err);
        check1("event_valid", data_valid, !mon_e.is_err);
        checkv("event_outhigh", outhigh, mon_e.oh);
        checki("event_latency", cyc, mon_e.cyc);
        check1("event_busy", busy, 1'b0);
      end
    end
  end

  // ---------------- bus driver ----------------
  task automatic half_bit();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic do_start();
    sda = 1'b0;
    model_start();
    half_bit();
    scl = 1'b0;
    half_bit();
  endtask

  task automatic do_bit(input bit b);
    sda = b;
    half_bit();
    scl = 1'b1;
    model_bit(b, cyc);
    half_bit();
    scl = 1'b0;
    half_bit();
  endtask

  task automatic do_stop();
    sda = 1'b0;
    half_bit();
    scl = 1'b1;
    model_bit(1'b0, cyc);
    half_bit();
    sda = 1'b1;
    model_stop(cyc);
    half_bit();
    half_bit();
    check1("busy_after_stop", busy, 1'b0);
  endtask

  task automatic do_rstart();
    sda = 1'b1;
    half_bit();
    scl = 1'b1;
    model_bit(1'b1, cyc);
    half_bit();
    sda = 1'b0;
    model_start();
    half_bit();
    scl = 1'b0;
    half_bit();
  endtask

  task automatic load_value(input logic [DATA_W-1:0] v);
    tx_q.delete();
    for (int i = DATA_W - 1; i >= 0; i--) tx_q.push_back(v[i]);
`ifdef S2P_PARITY_EN
    tx_q.push_back(^v);
`endif
  endtask

  task automatic send_tx();
    do_start();
    foreach (tx_q[i]) do_bit(tx_q[i]);
    do_stop();
  endtask

  task automatic send_value(input logic [DATA_W-1:0] v);
    load_value(v);
    send_tx();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    int k;
    rst_n = 1'b0;
    scl   = 1'b1;
    sda   = 1'b1;
    repeat (3) @(negedge clk);
    checkv("reset_outhigh", outhigh, '0);
    check1("reset_valid", data_valid, 1'b0);
    check1("reset_err", frame_err, 1'b0);
    check1("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    half_bit();

    send_value(4'd0);
    checkv("tp_v0", outhigh, 16'h8000);
    send_value(4'd1);
    checkv("tp_v1", outhigh, 16'h0001);
    send_value(4'd11);
    checkv("tp_v11", outhigh, 16'h0400);

    // short frame
    do_start();
    check1("busy_in_frame", busy, 1'b1);
    do_bit(1'b1);
    do_bit(1'b0);
    do_stop();
    checkv("tp_short_hold", outhigh, 16'h0400);

    // extra bit after a full frame
    tx_q.delete();
    for (int i = 0; i < FRAME_BITS; i++) tx_q.push_back(1'b1);
    do_start();
    foreach (tx_q[i]) do_bit(tx_q[i]);
    do_bit(1'b1);
    do_stop();
    checkv("tp_extra_hold", outhigh, 16'h0400);

    // repeated start after two bits
    do_start();
    do_bit(1'b1);
    do_bit(1'b0);
    do_rstart();
    load_value(4'd3);
    foreach (tx_q[i]) do_bit(tx_q[i]);
    do_stop();
    checkv("tp_rstart_v3", outhigh, 16'h0004);

    // reset in the middle of a frame
    do_start();
    do_bit(1'b1);
    do_bit(1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkv("midreset_outhigh", outhigh, '0);
    check1("midreset_busy", busy, 1'b0);
    check1("midreset_valid", data_valid, 1'b0);
    check1("midreset_err", frame_err, 1'b0);
    model_oh = '0;
    in_frame = 1'b0;
    scl = 1'b1;
    sda = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    half_bit();
`ifdef S2P_PARITY_EN
    tx_q.delete();
    tx_q.push_back(1'b0); tx_q.push_back(1'b1); tx_q.push_back(1'b0); tx_q.push_back(1'b1);
    tx_q.push_back(1'b1);
    send_tx();
    checkv("tp_parity_bad_hold", outhigh, '0);
`endif
    send_value(4'd5);
    checkv("tp_v5", outhigh, 16'h0010);

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 5) begin
        load_value(4'($urandom_range(0, 15)));
`ifdef S2P_PARITY_EN
        if (kind == 5) tx_q[FRAME_BITS-1] = ~tx_q[FRAME_BITS-1];
`endif
        send_tx();
      end else if (kind <= 7) begin
        k = int'($urandom_range(0, FRAME_BITS - 2));
        do_start();
        for (int i = 0; i < k; i++) do_bit(1'($urandom_range(0, 1)));
        do_stop();
      end else if (kind == 8) begin
        do_start();
        for (int i = 0; i < FRAME_BITS; i++) do_bit(1'($urandom_range(0, 1)));
        do_bit(1'b1);
        do_stop();
      end else begin
        k = int'($urandom_range(0, FRAME_BITS - 2));
        do_start();
        for (int i = 0; i < k; i++) do_bit(1'($urandom_range(0, 1)));
        do_rstart();
        load_value(4'($urandom_range(0, 15)));
        foreach (tx_q[i]) do_bit(tx_q[i]);
        do_stop();
      end
      checkv("random_outhigh", outhigh, model_oh);
    end

    repeat (20) @(negedge clk);
    checki("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
